// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Brief    : Bit-serial adder. One full-adder cell and a carry flop process
//             one operand bit per clock, LSB first. The block uses a
//             start/busy/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_res;
   logic             r_c;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;

   logic             w_s;
   logic             w_c_next;
   logic [WIDTH-1:0] w_res_next;

   // Full-adder cell on the current LSBs plus the carry flop
   assign w_s        = r_a_sr[0] ^ r_b_sr[0] ^ r_c;
   assign w_c_next   = (r_a_sr[0] & r_b_sr[0]) | (r_c & (r_a_sr[0] ^ r_b_sr[0]));
   assign w_res_next = {w_s, r_res[WIDTH-1:1]};

   // Control FSM and datapath: load on accept, one bit per RUN edge, publish on last bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a_sr  <= '0;
         r_b_sr  <= '0;
         r_res   <= '0;
         r_c     <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a_sr  <= a;
                  r_b_sr  <= b;
                  r_c     <= cin;
                  r_res   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               // start is deliberately ignored here; nothing is queued
               r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
               r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
               r_res  <= w_res_next;
               r_c    <= w_c_next;
               r_cnt  <= r_cnt + CW'(1);
               if (r_cnt == c_last) begin
                  r_sum   <= w_res_next;
                  r_cout  <= w_c_next;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Brief    : Self-checking bench for serial_adder against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int n_checks;
   int n_fail;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the full WIDTH+1-bit sum of the operands
   function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
   endfunction

   // Present a one-cycle start; returns at the negedge right after the accepting edge
   task automatic pulse_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      @(negedge clk);
      start = 1'b1; a = x; b = y; cin = c;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
   endtask

   // Advance until done is seen; k0 = negedges already elapsed since the accept edge
   task automatic wait_done(input int k0, output int edges, output int busy_cyc,
                            output bit sum_moved, output bit timeout);
      int k;
      logic [W-1:0] s0;
      k = k0; s0 = sum; busy_cyc = 0; sum_moved = 1'b0; timeout = 1'b0;
      while (done !== 1'b1) begin
         if (busy === 1'b1) busy_cyc++;
         if (sum !== s0) sum_moved = 1'b1;
         if (k > 4 * W) begin
            timeout = 1'b1;
            break;
         end
         @(negedge clk);
         k++;
      end
      edges = k - 1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'h00; cin = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
      n_checks++; if (sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum got=%h exp=00", sum); end
      n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b exp=0", cout); end
      rst_n = 1'b1; start = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++; if (busy !== 1'b0 || done !== 1'b0)
         begin n_fail++; $display("FAIL reset_idle busy=%b done=%b exp=0/0", busy, done); end
   endtask

   task automatic test_basic;
      int e, bc; bit sm, to;
      pulse_start(8'h3C, 8'h05, 1'b0);
      wait_done(1, e, bc, sm, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got=%b exp=0", to); end
      n_checks++; if (e !== W) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", e, W); end
      n_checks++; if (bc !== W) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", bc, W); end
      n_checks++; if (sm !== 1'b0) begin n_fail++; $display("FAIL basic_sum_stable got=%b exp=0", sm); end
      n_checks++; if (sum !== 8'h41) begin n_fail++; $display("FAIL basic_sum got=%h exp=41", sum); end
      n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL basic_cout got=%b exp=0", cout); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
      n_checks++; if (sum !== 8'h41) begin n_fail++; $display("FAIL basic_sum_hold got=%h exp=41", sum); end
   endtask

   task automatic test_carry;
      logic [W-1:0] va [3] = '{8'hFF, 8'hFF, 8'h00};
      logic [W-1:0] vb [3] = '{8'h01, 8'hFF, 8'h00};
      logic         vc [3] = '{1'b0, 1'b1, 1'b1};
      logic [W-1:0] es [3] = '{8'h00, 8'hFF, 8'h01};
      logic         ec [3] = '{1'b1, 1'b1, 1'b0};
      int e, bc; bit sm, to;
      for (int i = 0; i < 3; i++) begin
         pulse_start(va[i], vb[i], vc[i]);
         wait_done(1, e, bc, sm, to);
         n_checks++; if (to !== 1'b0 || e !== W)
            begin n_fail++; $display("FAIL carry%0d_latency got=%0d timeout=%b exp=%0d", i, e, to, W); end
         n_checks++; if (sum !== es[i])
            begin n_fail++; $display("FAIL carry%0d_sum got=%h exp=%h", i, sum, es[i]); end
         n_checks++; if (cout !== ec[i])
            begin n_fail++; $display("FAIL carry%0d_cout got=%b exp=%b", i, cout, ec[i]); end
      end
   endtask

   task automatic test_start_during_busy;
      int e, bc; bit sm, to; int extra;
      pulse_start(8'h10, 8'h20, 1'b0);
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(4, e, bc, sm, to);
      n_checks++; if (to !== 1'b0 || e !== W)
         begin n_fail++; $display("FAIL busy_start_latency got=%0d timeout=%b exp=%0d", e, to, W); end
      n_checks++; if (sum !== 8'h30) begin n_fail++; $display("FAIL busy_start_sum got=%h exp=30", sum); end
      n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL busy_start_cout got=%b exp=0", cout); end
      extra = 0;
      for (int i = 0; i < 2 * W + 2; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) extra++;
      end
      n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL busy_start_queued got=%0d exp=0", extra); end
   endtask

   task automatic test_back_to_back;
      int e, bc; bit sm, to;
      pulse_start(8'h12, 8'h34, 1'b0);
      repeat (W - 1) @(negedge clk);
      start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
      @(negedge clk);
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done got=%b exp=1", done); end
      n_checks++; if (sum !== 8'h46 || cout !== 1'b0)
         begin n_fail++; $display("FAIL b2b_first_result got=%b_%h exp=0_46", cout, sum); end
      @(negedge clk);
      start = 1'b0;
      n_checks++; if (busy !== 1'b1 || done !== 1'b0)
         begin n_fail++; $display("FAIL b2b_accept busy=%b done=%b exp=1/0", busy, done); end
      wait_done(1, e, bc, sm, to);
      n_checks++; if (to !== 1'b0 || e !== W)
         begin n_fail++; $display("FAIL b2b_latency got=%0d timeout=%b exp=%0d", e, to, W); end
      n_checks++; if (sum !== 8'h00 || cout !== 1'b1)
         begin n_fail++; $display("FAIL b2b_second_result got=%b_%h exp=1_00", cout, sum); end
   endtask

   task automatic test_mid_reset;
      int e, bc; bit sm, to; int seen;
      pulse_start(8'h7F, 8'h01, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0)
         begin n_fail++; $display("FAIL midrst_async got=%b%b_%b_%h exp=00_0_00", busy, done, cout, sum); end
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      rst_n = 1'b1;
      repeat (2 * W) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d exp=0", seen); end
      pulse_start(8'h7F, 8'h01, 1'b0);
      wait_done(1, e, bc, sm, to);
      n_checks++; if (to !== 1'b0 || e !== W)
         begin n_fail++; $display("FAIL midrst_fresh_latency got=%0d timeout=%b exp=%0d", e, to, W); end
      n_checks++; if (sum !== 8'h80 || cout !== 1'b0)
         begin n_fail++; $display("FAIL midrst_fresh_result got=%b_%h exp=0_80", cout, sum); end
   endtask

   task automatic test_random;
      int e, bc; bit sm, to;
      logic [W-1:0] x, y; logic c; logic [W:0] exp_r;
      for (int i = 0; i < 40; i++) begin
         x = W'($urandom); y = W'($urandom); c = 1'($urandom);
         exp_r = model_add(x, y, c);
         pulse_start(x, y, c);
         wait_done(1, e, bc, sm, to);
         n_checks++; if (to !== 1'b0 || e !== W || bc !== W)
            begin n_fail++; $display("FAIL rand%0d_timing lat=%0d busy=%0d timeout=%b exp=%0d", i, e, bc, to, W); end
         n_checks++; if ({cout, sum} !== exp_r)
            begin n_fail++; $display("FAIL rand%0d_result a=%h b=%h cin=%b got=%h exp=%h", i, x, y, c, {cout, sum}, exp_r); end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      test_reset();
      test_basic();
      test_carry();
      test_start_during_busy();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
